// File: rtl/aes_word_bridge.sv
// aes_word_bridge: word-serial bridge that gathers a 128-bit block, loads the AES core,
// waits for it to finish, then returns the result as four 32-bit words.
module aes_word_bridge (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_we_i,
    input  logic [2:0]   key_addr_i,
    input  logic [31:0]  key_word_i,
    input  logic [1:0]   size_i,
    input  logic         dec_i,
    input  logic         in_valid_i,
    input  logic [31:0]  in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [31:0]  out_data_o,
    input  logic         out_ready_i,
    output logic         core_load_o,
    output logic [255:0] core_key_o,
    output logic [127:0] core_data_o,
    output logic [1:0]   core_size_o,
    output logic         core_dec_o,
    input  logic [127:0] core_data_i,
    input  logic         core_busy_i,
    output logic         busy_o
);
    typedef enum logic [1:0] {COLLECT, LOAD, WAIT, DRAIN} state_t;
    state_t state, state_n;
    logic [1:0] cnt, idx;
    logic first;
    logic [127:0] res_q;
    // the core raises busy only in the cycle after the load edge, so that cycle is skipped
    logic done;
    assign done = state == WAIT && !first && !core_busy_i;
    always_comb begin
        state_n = state;
        case (state)
            COLLECT: state_n = in_valid_i && cnt == 2'd3 ? LOAD : COLLECT;
            LOAD:    state_n = WAIT;
            WAIT:    state_n = done ? DRAIN : WAIT;
            DRAIN:   state_n = out_ready_i && idx == 2'd3 ? COLLECT : DRAIN;
            default: state_n = COLLECT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= COLLECT;
            cnt         <= '0;
            idx         <= '0;
            first       <= 1'b0;
            core_key_o  <= '0;
            core_data_o <= '0;
            core_size_o <= '0;
            core_dec_o  <= 1'b0;
            res_q       <= '0;
        end else begin
            state <= state_n;
            first <= state == LOAD;
            if (key_we_i && (state == COLLECT || state == DRAIN))
                core_key_o[{~key_addr_i, 5'b0} +: 32] <= key_word_i;
            if (state == COLLECT && in_valid_i) begin
                core_data_o[{~cnt, 5'b0} +: 32] <= in_data_i;
                cnt <= cnt + 2'd1;
                if (cnt == 2'd0) begin
                    core_size_o <= size_i;
                    core_dec_o  <= dec_i;
                end
            end
            if (done)
                res_q <= core_data_i;
            if (state == DRAIN && out_ready_i)
                idx <= idx + 2'd1;
        end
    end
    assign in_ready_o  = state == COLLECT;
    assign out_valid_o = state == DRAIN;
    assign out_data_o  = res_q[{~idx, 5'b0} +: 32];
    assign core_load_o = state == LOAD;
    assign busy_o      = state == LOAD || state == WAIT;
endmodule

// File: tb/tb_aes_word_bridge.sv
// tb_aes_word_bridge: directed bench with a stand-in AES core and a block-level
// scoreboard of expected output words.
module tb_aes_word_bridge;
    logic clk = 0, rst = 1;
    logic key_we = 0;
    logic [2:0] key_addr = 0;
    logic [31:0] key_word = 0;
    logic [1:0] size = 0;
    logic dec = 0, in_valid = 0, in_ready, out_valid, out_ready = 1;
    logic [31:0] in_data = 0, out_data;
    logic core_load, core_dec, core_busy, busy;
    logic [255:0] core_key;
    logic [127:0] core_data, core_res;
    logic [1:0] core_size;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;

    aes_word_bridge dut (
        .clk(clk), .rst(rst), .key_we_i(key_we), .key_addr_i(key_addr), .key_word_i(key_word),
        .size_i(size), .dec_i(dec), .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
        .core_load_o(core_load), .core_key_o(core_key), .core_data_o(core_data),
        .core_size_o(core_size), .core_dec_o(core_dec), .core_data_i(core_res),
        .core_busy_i(core_busy), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Stand-in cipher: FIPS-197 AES-128 vector pair, otherwise an arbitrary mix.
    function automatic logic [127:0] aes_ref(input logic [255:0] k, input logic [127:0] d,
                                             input logic [1:0] s, input logic dc);
        if (s == 2'd0 && k[255:128] == K128 && !dc && d == PT) return CT;
        if (s == 2'd0 && k[255:128] == K128 && dc && d == CT) return PT;
        return d ^ k[255:128] ^ k[127:0] ^ {dc, s, 125'd0};
    endfunction

    // Core model: busy for 11 cycles after the load, garbage on the data bus while busy.
    logic cbusy = 0;
    int bcnt = 0;
    logic [127:0] cres = 0;
    always @(posedge clk) begin
        if (core_load) begin
            cbusy <= 1;
            bcnt  <= 10;
            cres  <= aes_ref(core_key, core_data, core_size, core_dec);
        end else if (cbusy) begin
            if (bcnt == 0) cbusy <= 0;
            else bcnt <= bcnt - 1;
        end
    end
    assign core_busy = cbusy;
    assign core_res  = cbusy ? {4{32'hdeadbeef}} : cres;

    int checks = 0, errors = 0;
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [31:0] key_m [8];
    function automatic logic [255:0] key_flat();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[255-32*i -: 32] = key_m[i];
        return k;
    endfunction

    logic [31:0] exp_q [$];
    logic [31:0] obs [$];
    logic [127:0] blk_m;
    logic [1:0] sz_m;
    logic dc_m, pending = 0, seen_valid = 0, b2b_chk = 0, bp = 0;
    logic prev_valid = 0, prev_ready = 0;
    logic [31:0] prev_data = 0;
    int acc_n = 0, xfer_n = 0, cyc = 0, acc_cyc = 0, loads = 0, last_xfer_cyc = -10;

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: inputs are driven 1 time unit after posedge, so negedge sees them settled.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_valid = 0;
        end else begin
            check("in_ready", in_ready, !pending);
            if (pending && core_load) loads++;
            if (prev_valid && !prev_ready) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && !seen_valid) begin
                seen_valid = 1;
                check("load_pulses", loads, 1);
                check("latency", cyc - acc_cyc, 14);
            end
            check("busy", busy, pending && !seen_valid);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: got %0h expected no output", out_data);
                end else begin
                    check("out_word", out_data, exp_q.pop_front());
                    obs.push_back(out_data);
                end
                xfer_n++;
                if (xfer_n == 4) begin
                    xfer_n = 0;
                    pending = 0;
                    last_xfer_cyc = cyc;
                end
            end
            if (in_valid && in_ready) begin
                if (b2b_chk && acc_n == 0) check("b2b_accept", cyc, last_xfer_cyc + 1);
                if (acc_n == 0) begin
                    sz_m = size;
                    dc_m = dec;
                end
                blk_m[127-32*acc_n -: 32] = in_data;
                acc_n++;
                if (acc_n == 4) begin
                    logic [127:0] r;
                    acc_n = 0;
                    pending = 1;
                    seen_valid = 0;
                    loads = 0;
                    acc_cyc = cyc;
                    r = aes_ref(key_flat(), blk_m, sz_m, dc_m);
                    for (int i = 0; i < 4; i++) exp_q.push_back(r[127-32*i -: 32]);
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_key(input int a, input logic [31:0] w, input logic apply);
        key_we = 1;
        key_addr = 3'(a);
        key_word = w;
        step();
        key_we = 0;
        if (apply) key_m[a] = w;
    endtask

    // size/dec are scrambled on words 1-3 to show only the first word's values count.
    task automatic send_block(input logic [127:0] b, input logic [1:0] s, input logic d);
        for (int i = 0; i < 4; i++) begin
            int g = 0;
            in_valid = 1;
            in_data = b[127-32*i -: 32];
            size = i == 0 ? s : ~s;
            dec = i == 0 ? d : ~d;
            @(negedge clk);
            while (!in_ready && g < 300) begin
                @(negedge clk);
                g++;
            end
            if (g >= 300) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got in_ready=0 expected 1 within 300 cycles");
            end
            step();
        end
        in_valid = 0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((pending || exp_q.size() != 0) && g < 400) begin
            step();
            g++;
        end
        check("drain_done", g < 400, 1);
    endtask

    task automatic check_obs(input logic [127:0] want);
        check("obs_count", obs.size(), 4);
        for (int i = 0; i < obs.size() && i < 4; i++) check("obs_word", obs[i], want[127-32*i -: 32]);
        obs.delete();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) key_m[i] = 0;
        repeat (3) step();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_load", core_load, 0);
        check("rst_key", core_key, 0);
        check("rst_data", core_data, 0);
        check("rst_size", core_size, 0);
        check("rst_dec", core_dec, 0);
        check("rst_busy", busy, 0);
        rst = 0;
        step();

        for (int i = 0; i < 4; i++) write_key(i, K128[127-32*i -: 32], 1);
        check("key_loaded", core_key[255:128], K128);

        send_block(PT, 2'd0, 1'b0);
        wait_idle();
        check_obs(CT);

        send_block(CT, 2'd0, 1'b1);
        wait_idle();
        check_obs(PT);

        send_block(PT, 2'd0, 1'b0);
        repeat (3) step();
        write_key(0, 32'hffffffff, 0);
        wait_idle();
        check("key_after_wait_write", core_key[255:224], 32'h00010203);
        check_obs(CT);

        for (int i = 4; i < 8; i++) write_key(i, 32'h10111213 * i, 1);
        bp = 1;
        send_block(128'h0123456789abcdeffedcba9876543210, 2'd2, 1'b0);
        send_block(128'hcafef00d0badc0de1234567855aa33cc, 2'd1, 1'b1);
        wait_idle();
        bp = 0;
        obs.delete();

        send_block(PT, 2'd0, 1'b0);
        repeat (4) step();
        rst = 1;
        step();
        for (int i = 0; i < 8; i++) key_m[i] = 0;
        exp_q.delete();
        obs.delete();
        pending = 0;
        acc_n = 0;
        xfer_n = 0;
        rst = 0;
        check("abort_out_valid", out_valid, 0);
        check("abort_key", core_key, 0);
        repeat (20) step();
        check("abort_no_output", obs.size(), 0);
        send_block(PT, 2'd0, 1'b0);
        wait_idle();
        check_obs(PT);

        for (int i = 0; i < 4; i++) write_key(i, K128[127-32*i -: 32], 1);
        send_block(PT, 2'd0, 1'b0);
        b2b_chk = 1;
        send_block(CT, 2'd0, 1'b1);
        b2b_chk = 0;
        wait_idle();
        check("b2b_count", obs.size(), 8);
        obs.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
